// File: rtl/instr_pkg.sv
// Shared types for the instruction fetch/issue path.
// Field layout of the 19-bit instruction word and fetch FSM states.
package instr_pkg;

  localparam int SEL_W  = 3;
  localparam int IMM_W  = 8;
  localparam int INSTR_W = SEL_W + 2 * IMM_W;

  localparam logic [INSTR_W-1:0] DEF_HALT_WORD = 19'h7FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [IMM_W-1:0] inm_a;
    logic [IMM_W-1:0] inm_b;
  } instr_t;

endpackage

// File: rtl/instr_fetch_issue_if.sv
// Issue-side valid/ready bundle between fetch and the ALU.
// master drives the instruction, slave returns ready.
interface instr_fetch_issue_if;
  import instr_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_sel;
  logic [IMM_W-1:0] out_inm_a;
  logic [IMM_W-1:0] out_inm_b;

  modport master (
    output out_valid,
    output out_sel,
    output out_inm_a,
    output out_inm_b,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_sel,
    input  out_inm_a,
    input  out_inm_b,
    output out_ready
  );

endinterface

// File: rtl/issue_reg.sv
// Single-entry valid/ready holding register for instr_t.
// load wins over accept, so a drain and refill can share a cycle.
module issue_reg
  import instr_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  instr_t din,
  input  logic   ready,
  output logic   valid,
  output instr_t dout,
  output logic   accept
);

  assign accept = valid && ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// ROM walker issuing instructions to the ALU over valid/ready.
// INSTR_FETCH_LOOP_EN: wrap pc after LAST_ADDR instead of draining.
module instr_fetch_issue
  import instr_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                WORD_W    = 19,
  parameter int                LAST_ADDR = 63,
  parameter logic [WORD_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [WORD_W-1:0]    rom_data,
  instr_fetch_issue_if.master  iss,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      issued_count
);

  localparam logic [ADDR_W:0] CNT_MAX = '1;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              push, clr, accept;
  logic              can_load, is_halt, at_last;
  instr_t            ir;

  assign can_load = !iss.out_valid || iss.out_ready;
  assign is_halt  = rom_data == HALT_WORD;
  assign at_last  = pc == ADDR_W'(LAST_ADDR);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          clr       = 1'b1;
        end
      end
      RUN: begin
        if (can_load) begin
          if (is_halt) begin
            state_nxt = DONE;
          end else begin
            push = 1'b1;
            if (at_last) begin
`ifdef INSTR_FETCH_LOOP_EN
              pc_nxt = '0;
`else
              state_nxt = DRAIN;
`endif
            end else begin
              pc_nxt = pc + ADDR_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (accept) state_nxt = DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      issued_count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // start only fires with out_valid low, so clr never meets accept
      if (clr)
        issued_count <= '0;
      else if (accept && issued_count != CNT_MAX)
        issued_count <= issued_count + 1'b1;
    end
  end

  issue_reg u_issue_reg (
    .clock  (clock),
    .reset  (reset),
    .load   (push),
    .din    (instr_t'(rom_data)),
    .ready  (iss.out_ready),
    .valid  (iss.out_valid),
    .dout   (ir),
    .accept (accept)
  );

  assign iss.out_sel   = ir.sel;
  assign iss.out_inm_a = ir.inm_a;
  assign iss.out_inm_b = ir.inm_b;

  assign rom_addr = pc;
  assign busy     = state == RUN || state == DRAIN;
  assign done     = state == DONE;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Scoreboard bench for instr_fetch_issue: halt, backpressure, drain,
// async reset, restart and (with INSTR_FETCH_LOOP_EN) pc wrap.
module tb_instr_fetch_issue;

`ifdef INSTR_FETCH_LOOP_EN
  localparam int L1 = 1;
`else
  localparam int L1 = 3;
`endif

  logic clock = 1'b0;
  logic reset;
  logic start0, start1;
  logic [5:0] addr0, addr1;
  logic busy0, busy1, done0, done1;
  logic [6:0] cnt0, cnt1;
  logic [18:0] rom0 [64];
  logic [18:0] rom1 [4];
  logic [18:0] exp_q [$];
  logic [18:0] got, exp_w;
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  instr_fetch_issue_if ifc0 ();
  instr_fetch_issue_if ifc1 ();

  instr_fetch_issue #(.LAST_ADDR(63)) dut0 (
    .clock        (clock),
    .reset        (reset),
    .start        (start0),
    .rom_addr     (addr0),
    .rom_data     (rom0[addr0]),
    .iss          (ifc0.master),
    .busy         (busy0),
    .done         (done0),
    .issued_count (cnt0)
  );

  instr_fetch_issue #(.LAST_ADDR(L1)) dut1 (
    .clock        (clock),
    .reset        (reset),
    .start        (start1),
    .rom_addr     (addr1),
    .rom_data     (rom1[addr1[1:0]]),
    .iss          (ifc1.master),
    .busy         (busy1),
    .done         (done1),
    .issued_count (cnt1)
  );

  function automatic logic [18:0] w(input int i);
    return {3'(i), 8'(8'h30 + i), 8'(8'hC0 + i)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    ifc0.out_ready = 1'b0;
    ifc1.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) rom0[i] = w(i);
    rom0[4] = 19'h7FFFF;
    for (int i = 0; i < 4; i++) rom1[i] = w(10 + i);
    tick();
    tick();
    got = {ifc0.out_sel, ifc0.out_inm_a, ifc0.out_inm_b};
    tests++;
    if (ifc0.out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_valid got %b exp 0", ifc0.out_valid);
    end
    tests++;
    if (got !== 19'h0) begin
      fails++; $display("FAIL rst_fields got %h exp 0", got);
    end
    tests++;
    if ({busy0, done0} !== 2'b00) begin
      fails++; $display("FAIL rst_busy_done got %b exp 00", {busy0, done0});
    end
    tests++;
    if (cnt0 !== 7'd0 || addr0 !== 6'd0) begin
      fails++; $display("FAIL rst_cnt_addr got %0d/%0d exp 0/0", cnt0, addr0);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_halt_run();
    for (int i = 0; i < 4; i++) exp_q.push_back(w(i));
    ifc0.out_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tests++;
    if (busy0 !== 1'b1 || ifc0.out_valid !== 1'b0) begin
      fails++; $display("FAIL halt_start got busy %b valid %b exp 1 0", busy0, ifc0.out_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++;
      if (ifc0.out_valid !== 1'b1) begin
        fails++; $display("FAIL halt_issue%0d got valid %b exp 1", i, ifc0.out_valid);
      end else begin
        got = {ifc0.out_sel, ifc0.out_inm_a, ifc0.out_inm_b};
        exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 19'hx;
        tests++;
        if (got !== exp_w) begin
          fails++; $display("FAIL halt_word%0d got %h exp %h", i, got, exp_w);
        end
      end
      tests++;
      if (cnt0 !== 7'(i - 1)) begin
        fails++; $display("FAIL halt_cnt%0d got %0d exp %0d", i, cnt0, i - 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (done0 !== 1'b1 || ifc0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
        fails++; $display("FAIL halt_done%0d got done %b valid %b busy %b exp 1 0 0",
                          i, done0, ifc0.out_valid, busy0);
      end
    end
    tests++;
    if (cnt0 !== 7'd4 || exp_q.size() != 0) begin
      fails++; $display("FAIL halt_final got cnt %0d left %0d exp 4 0", cnt0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) exp_q.push_back(w(i));
    ifc0.out_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tests++;
    if (cnt0 !== 7'd0 || addr0 !== 6'd0 || done0 !== 1'b0) begin
      fails++; $display("FAIL restart got cnt %0d addr %0d done %b exp 0 0 0", cnt0, addr0, done0);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      ifc0.out_ready = !(i >= 2 && i <= 4);
      got = {ifc0.out_sel, ifc0.out_inm_a, ifc0.out_inm_b};
      if (!ifc0.out_ready) begin
        tests++;
        if (got !== w(1) || addr0 !== 6'd2 || cnt0 !== 7'd1 || ifc0.out_valid !== 1'b1) begin
          fails++; $display("FAIL bp_hold%0d got %h addr %0d cnt %0d exp %h 2 1",
                            i, got, addr0, cnt0, w(1));
        end
      end else if (ifc0.out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL bp_extra got %h exp none", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin
            fails++; $display("FAIL bp_word%0d got %h exp %h", i, got, exp_w);
          end
        end
      end
    end
    tests++;
    if (done0 !== 1'b1 || cnt0 !== 7'd4 || exp_q.size() != 0) begin
      fails++; $display("FAIL bp_final got done %b cnt %0d left %0d exp 1 4 0",
                        done0, cnt0, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    ifc0.out_ready = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if (cnt0 !== 7'd2 || busy0 !== 1'b1) begin
      fails++; $display("FAIL ar_pre got cnt %0d busy %b exp 2 1", cnt0, busy0);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (ifc0.out_valid !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 7'd0) begin
      fails++; $display("FAIL ar_drop got valid %b busy %b cnt %0d exp 0 0 0",
                        ifc0.out_valid, busy0, cnt0);
    end
    tests++;
    if (done0 !== 1'b0 || addr0 !== 6'd0) begin
      fails++; $display("FAIL ar_idle got done %b addr %0d exp 0 0", done0, addr0);
    end
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

`ifndef INSTR_FETCH_LOOP_EN
  task automatic test_drain();
    for (int i = 0; i < 4; i++) exp_q.push_back(w(10 + i));
    ifc1.out_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      ifc1.out_ready = !(i >= 4 && i <= 6);
      got = {ifc1.out_sel, ifc1.out_inm_a, ifc1.out_inm_b};
      if (!ifc1.out_ready) begin
        tests++;
        if (got !== w(13) || ifc1.out_valid !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) begin
          fails++; $display("FAIL drain_hold%0d got %h valid %b busy %b done %b exp %h 1 1 0",
                            i, got, ifc1.out_valid, busy1, done1, w(13));
        end
      end else if (ifc1.out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL drain_extra got %h exp none", got);
        end else begin
          exp_w = exp_q.pop_front();
          if (got !== exp_w) begin
            fails++; $display("FAIL drain_word%0d got %h exp %h", i, got, exp_w);
          end
        end
      end
    end
    tests++;
    if (done1 !== 1'b1 || cnt1 !== 7'd4 || ifc1.out_valid !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL drain_final got done %b cnt %0d valid %b left %0d exp 1 4 0 0",
                        done1, cnt1, ifc1.out_valid, exp_q.size());
    end
  endtask
`else
  task automatic test_loop();
    for (int i = 0; i < 6; i++) exp_q.push_back(w(10 + (i % 2)));
    ifc1.out_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      got = {ifc1.out_sel, ifc1.out_inm_a, ifc1.out_inm_b};
      exp_w = exp_q.size() != 0 ? exp_q.pop_front() : 19'hx;
      tests++;
      if (ifc1.out_valid !== 1'b1 || got !== exp_w || done1 !== 1'b0) begin
        fails++; $display("FAIL loop%0d got valid %b %h done %b exp 1 %h 0",
                          i, ifc1.out_valid, got, done1, exp_w);
      end
    end
    tests++;
    if (cnt1 !== 7'd5 || busy1 !== 1'b1) begin
      fails++; $display("FAIL loop_cnt got %0d busy %b exp 5 1", cnt1, busy1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_halt_run();
    test_backpressure();
    test_async_reset();
`ifndef INSTR_FETCH_LOOP_EN
    test_drain();
`else
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Upstream issue stage for the ALU datapath; replaces the free-running program counter.
- Walks the instruction ROM from address 0 and registers each 19-bit word.
- Splits each word into select / immediate A / immediate B and presents it to the ALU with a valid/ready handshake.
- Stops on a halt sentinel word or after the last address, and reports completion.

Parameters:
- ADDR_W, 6: ROM address width; program counter width.
- WORD_W, 19: instruction width. Layout: [18:16] select, [15:8] inm_A, [7:0] inm_B.
- LAST_ADDR, 63: highest ROM address executed.
- HALT_WORD, 19'h7FFFF: sentinel word. It is never issued and ends the program.

Ports:
- clock, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high; clears all state immediately.
- start, in, 1: one-cycle request to begin execution at address 0.
- rom_addr, out, ADDR_W: combinational ROM address, equal to pc.
- rom_data, in, WORD_W: combinational ROM read data for rom_addr.
- out_valid, out, 1: issue register holds a valid instruction.
- out_ready, in, 1: ALU/consumer accepts the instruction when out_valid && out_ready.
- out_sel, out, 3: registered select field.
- out_inm_a, out, 8: registered immediate A.
- out_inm_b, out, 8: registered immediate B.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: high in DONE.
- issued_count, out, ADDR_W+1: number of accepted instructions since the last start.

Behaviour:
- Reset values:
  - state = IDLE; pc = 0; out_valid = 0.
  - out_sel / out_inm_a / out_inm_b = 0.
  - issued_count = 0; busy = 0; done = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Holds outputs; out_valid = 0.
  - start = 1 → pc <= 0, issued_count <= 0, go to RUN.
- RUN:
  - Load condition: load = !out_valid || out_ready.
  - When load and rom_data != HALT_WORD:
    - Register the fields of rom_data; out_valid <= 1.
    - If pc == LAST_ADDR → go to DRAIN (pc holds); else pc <= pc + 1.
  - When load and rom_data == HALT_WORD: out_valid <= 0, go to DONE, pc holds.
  - When !load: registers, pc and state hold. Fields stay stable while out_valid && !out_ready.
- DRAIN:
  - Nothing further is loaded.
  - The final instruction stays presented until accepted; on out_ready, out_valid <= 0 and go to DONE.
- DONE:
  - done = 1; out_valid = 0.
  - start = 1 → restart exactly as from IDLE.
- Latency:
  - start sampled at edge k → address-0 word valid after edge k+1.
  - With out_ready held at 1, throughput is one instruction per cycle.
- issued_count:
  - Increments on every accepted handshake (out_valid && out_ready) in any state.
  - Saturates at 2^(ADDR_W+1)-1.
- Simultaneous events:
  - An acceptance in the same cycle as a new load is counted, and the new word is loaded.
  - start in RUN or DRAIN is ignored.
- Reset mid-operation: an in-flight instruction is discarded with no handshake; all values return to their reset values asynchronously.
- No arithmetic on the instruction data; fields pass through unchanged.

Optional Feature:
- Macro: INSTR_FETCH_LOOP_EN.
- Defined:
  - After issuing the LAST_ADDR word, pc wraps to 0 and the block stays in RUN; DRAIN is unused.
  - Execution ends only on HALT_WORD; issued_count still saturates.
- Undefined: behaviour exactly as above (finishes through DRAIN at LAST_ADDR).

Decomposition:
- Shared package instr_pkg:
  - Typedef fetch_state_t (IDLE, RUN, DRAIN, DONE).
  - Typedef instr_t: packed struct of sel[2:0], inm_a[7:0], inm_b[7:0], totalling 19 bits.
  - Constants SEL_W = 3, IMM_W = 8, default HALT_WORD.
- One sub-module: issue_reg.
  - A single-entry valid/ready holding register for instr_t, with a load input and accept output.
  - Reused later by the ALU result stage.

Test Plan:
- Load ROM words 0..3 with distinct values and word 4 = 19'h7FFFF; hold out_ready = 1; pulse start.
  - Expected: four consecutive issues on consecutive cycles.
  - Expected: done asserts the cycle after word 3 is accepted; issued_count = 4; word 4 never appears.
- Backpressure: drop out_ready for 3 cycles while word 1 is valid.
  - Expected: out_sel / out_inm_a / out_inm_b stable; rom_addr stays 2; no count increment.
  - Expected: after release, words 2 and 3 follow in order.
- LAST_ADDR = 3 with no halt word and out_ready = 0 when word 3 loads.
  - Expected: DRAIN holds word 3.
  - Expected: raising out_ready gives one acceptance, then done = 1 and issued_count = 4.
- Assert reset asynchronously between clock edges in RUN.
  - Expected: out_valid, busy and issued_count drop immediately; state is IDLE; rom_addr = 0.
- Pulse start again in DONE.
  - Expected: address 0 re-issued; issued_count restarts from 0.
- With INSTR_FETCH_LOOP_EN, LAST_ADDR = 1, HALT_WORD at no address, 6 ready cycles.
  - Expected: issue sequence 0,1,0,1,0,1; done stays 0.
